// File: rtl/seg_display_scanner.sv
// seg_display_scanner: double-buffered multiplexed scan of NUM_DIGITS nibbles with blanking guard and leading-zero suppression
module seg_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic                    blank_lz,
    output logic [3:0]              hex_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [NUM_DIGITS-1:0][3:0] shadow, disp, disp_n;
    logic [NUM_DIGITS-1:0] shadow_dp, disp_dp, disp_dp_n, upper_zero, sel_n;
    logic wrap, boundary, pending_n, lit, z;

    always_comb begin
        wrap = cnt == CNT_LAST;
        boundary = wrap && idx == IDX_LAST;
        cnt_n = wrap ? '0 : cnt + 1'b1;
        idx_n = !wrap ? idx : (idx == IDX_LAST ? '0 : idx + 1'b1);
        // a write landing on the frame edge bypasses shadow entirely
        disp_n = !boundary ? disp : wr_en ? wr_data : pending ? shadow : disp;
        disp_dp_n = !boundary ? disp_dp : wr_en ? wr_dp : pending ? shadow_dp : disp_dp;
        pending_n = !boundary && (wr_en || pending);
        z = 1'b1;
        upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            z = z && disp_n[k] == 4'd0;
            upper_zero[k] = z;
        end
        lit = cnt_n >= BLANK_END && !(blank_lz && idx_n != '0 && upper_zero[idx_n]);
        sel_n = lit ? SEL_OFF ^ (NUM_DIGITS'(1) << idx_n) : SEL_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            shadow <= '0;
            shadow_dp <= '0;
            pending <= 1'b0;
            disp <= '0;
            disp_dp <= '0;
            hex_out <= 4'd0;
            dp_out <= 1'b0;
            digit_sel <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt <= cnt_n;
            idx <= idx_n;
            if (wr_en) begin
                shadow <= wr_data;
                shadow_dp <= wr_dp;
            end
            pending <= pending_n;
            disp <= disp_n;
            disp_dp <= disp_dp_n;
            hex_out <= disp_n[idx_n];
            dp_out <= disp_dp_n[idx_n];
            digit_sel <= sel_n;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: scenario tasks with a per-slot scoreboard of expected display output
module tb_seg_display_scanner;
    localparam int N = 4;
    localparam int DIV = 8;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic blank_lz = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0] wr_dp = '0;
    logic [3:0] hex_out;
    logic dp_out;
    logic [3:0] digit_sel;
    logic frame_done;
    logic pending;

    int checks = 0;
    int fails = 0;
    // [11:8] digit_sel in show phase, [5] frame_done, [4] dp, [3:0] hex
    logic [11:0] sb[$];

    seg_display_scanner #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BL), .SEL_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp), .blank_lz(blank_lz),
        .hex_out(hex_out), .dp_out(dp_out), .digit_sel(digit_sel), .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sel_of(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return 4'hF ^ one;
    endfunction

    task automatic write(input logic [15:0] d, input logic [3:0] p);
        wr_en = 1'b1;
        wr_data = d;
        wr_dp = p;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = frame_done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (digit_sel !== 4'hF) begin fails++; $display("FAIL reset_sel: got %h expected f", digit_sel); end
        if (hex_out !== 4'h0) begin fails++; $display("FAIL reset_hex: got %h expected 0", hex_out); end
        if (dp_out !== 1'b0) begin fails++; $display("FAIL reset_dp: got %b expected 0", dp_out); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        if (pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b expected 0", pending); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [11:0] it;
        for (int e = 1; e <= 32; e++)
            sb.push_back({((e % DIV) < BL) ? 4'hF : sel_of((e / DIV) % N), 2'b00, e == 32, 1'b0, 4'h0});
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk);
            it = sb.pop_front();
            checks += 3;
            if (digit_sel !== it[11:8]) begin fails++; $display("FAIL idle_sel e=%0d: got %h expected %h", e, digit_sel, it[11:8]); end
            if (hex_out !== it[3:0]) begin fails++; $display("FAIL idle_hex e=%0d: got %h expected %h", e, hex_out, it[3:0]); end
            if (frame_done !== it[5]) begin fails++; $display("FAIL idle_fd e=%0d: got %b expected %b", e, frame_done, it[5]); end
        end
    endtask

    task automatic test_write();
        logic [11:0] it;
        bit ok;
        repeat (10) @(negedge clk);
        sb.push_back({sel_of(0), 3'b000, 1'b0, 4'hF});
        sb.push_back({sel_of(1), 3'b000, 1'b0, 4'h3});
        sb.push_back({sel_of(2), 3'b000, 1'b1, 4'hA});
        sb.push_back({sel_of(3), 3'b000, 1'b0, 4'h1});
        write(16'h1A3F, 4'b0100);
        checks++;
        if (pending !== 1'b1) begin fails++; $display("FAIL write_pending_set: got %b expected 1", pending); end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = frame_done;
            if (!ok) begin
                checks++;
                if (pending !== 1'b1) begin fails++; $display("FAIL write_pending_hold: got %b expected 1", pending); end
            end
        end
        checks += 2;
        if (!ok) begin fails++; $display("FAIL write_timeout: got no frame_done expected one within 40 cycles"); end
        if (pending !== 1'b0) begin fails++; $display("FAIL write_pending_clr: got %b expected 0", pending); end
        for (int s = 0; s < N; s++) begin
            it = sb.pop_front();
            checks += 2;
            if (hex_out !== it[3:0]) begin fails++; $display("FAIL write_hex_blank s=%0d: got %h expected %h", s, hex_out, it[3:0]); end
            if (dp_out !== it[4]) begin fails++; $display("FAIL write_dp s=%0d: got %b expected %b", s, dp_out, it[4]); end
            repeat (4) @(negedge clk);
            checks += 3;
            if (digit_sel !== it[11:8]) begin fails++; $display("FAIL write_sel s=%0d: got %h expected %h", s, digit_sel, it[11:8]); end
            if (hex_out !== it[3:0]) begin fails++; $display("FAIL write_hex_show s=%0d: got %h expected %h", s, hex_out, it[3:0]); end
            if (dp_out !== it[4]) begin fails++; $display("FAIL write_dp_show s=%0d: got %b expected %b", s, dp_out, it[4]); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] it;
        bit ok;
        repeat (3) @(negedge clk);
        for (int s = 0; s < N; s++) sb.push_back({sel_of(s), 4'b0000, 4'h2});
        write(16'h1111, 4'b0000);
        repeat (2) @(negedge clk);
        write(16'h2222, 4'b0000);
        wait_frame(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL b2b_timeout: got no frame_done expected one within 40 cycles"); end
        for (int s = 0; s < N; s++) begin
            it = sb.pop_front();
            for (int c = 0; c < DIV; c++) begin
                checks++;
                if (hex_out !== it[3:0]) begin fails++; $display("FAIL b2b_hex s=%0d c=%0d: got %h expected %h", s, c, hex_out, it[3:0]); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [11:0] it;
        bit ok;
        blank_lz = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                sb.push_back({4'hE, 4'b0000, 4'h0});
                sb.push_back({4'hD, 4'b0000, 4'h5});
                sb.push_back({4'hF, 4'b0000, 4'h0});
                sb.push_back({4'hF, 4'b0000, 4'h0});
            end else begin
                sb.push_back({4'hE, 4'b0000, 4'h0});
                for (int s = 1; s < N; s++) sb.push_back({4'hF, 4'b0000, 4'h0});
            end
            write(p == 0 ? 16'h0050 : 16'h0000, 4'b0000);
            wait_frame(ok);
            checks++;
            if (!ok) begin fails++; $display("FAIL lz_timeout p=%0d: got no frame_done expected one within 40 cycles", p); end
            for (int s = 0; s < N; s++) begin
                it = sb.pop_front();
                for (int c = 0; c < DIV; c++) begin
                    checks += 2;
                    if (digit_sel !== (c < BL ? 4'hF : it[11:8])) begin
                        fails++;
                        $display("FAIL lz_sel p=%0d s=%0d c=%0d: got %h expected %h", p, s, c, digit_sel, c < BL ? 4'hF : it[11:8]);
                    end
                    if (hex_out !== it[3:0]) begin fails++; $display("FAIL lz_hex p=%0d s=%0d c=%0d: got %h expected %h", p, s, c, hex_out, it[3:0]); end
                    @(negedge clk);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_coincident();
        logic [11:0] it;
        repeat (31) @(negedge clk);
        sb.push_back({sel_of(0), 4'b0000, 4'hF});
        sb.push_back({sel_of(1), 4'b0000, 4'hE});
        sb.push_back({sel_of(2), 4'b0000, 4'hE});
        sb.push_back({sel_of(3), 4'b0000, 4'hB});
        write(16'hBEEF, 4'b0000);
        checks++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL coin_fd: got %b expected 1", frame_done); end
        for (int s = 0; s < N; s++) begin
            it = sb.pop_front();
            for (int c = 0; c < DIV; c++) begin
                checks += 2;
                if (hex_out !== it[3:0]) begin fails++; $display("FAIL coin_hex s=%0d c=%0d: got %h expected %h", s, c, hex_out, it[3:0]); end
                if (pending !== 1'b0) begin fails++; $display("FAIL coin_pending s=%0d c=%0d: got %b expected 0", s, c, pending); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] it;
        repeat (20) @(negedge clk);
        checks += 2;
        if (digit_sel !== 4'hB) begin fails++; $display("FAIL ar_pre_sel: got %h expected b", digit_sel); end
        if (hex_out !== 4'hE) begin fails++; $display("FAIL ar_pre_hex: got %h expected e", hex_out); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (digit_sel !== 4'hF) begin fails++; $display("FAIL ar_sel: got %h expected f", digit_sel); end
        if (hex_out !== 4'h0) begin fails++; $display("FAIL ar_hex: got %h expected 0", hex_out); end
        if (dp_out !== 1'b0) begin fails++; $display("FAIL ar_dp: got %b expected 0", dp_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++)
            sb.push_back({((e % DIV) < BL) ? 4'hF : sel_of((e / DIV) % N), 4'b0000, 4'h0});
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            it = sb.pop_front();
            checks += 2;
            if (digit_sel !== it[11:8]) begin fails++; $display("FAIL ar_restart_sel e=%0d: got %h expected %h", e, digit_sel, it[11:8]); end
            if (hex_out !== it[3:0]) begin fails++; $display("FAIL ar_restart_hex e=%0d: got %h expected %h", e, hex_out, it[3:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write();
        test_back_to_back();
        test_blank_lz();
        test_coincident();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
